game_sequencer: RTL and testbench

Top-level game-flow controller for the Blobby Volley datapath.
- Sequences menu, serve, rally, point pause and game-over phases.
- Owns both score counters and gates the physics engine (run and reposition).
- Drives the menu overlay enable and the endgame flag consumed by the menu and score renderers.
- Timing is frame-based, using a frame tick derived from the VGA vsync.

---
 rtl/game_sequencer_if.sv | 49 ++++
 rtl/game_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_game_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | game_sequencer_if : bus between game_sequencer and the Blobby datapath      |
// | Optional GAME_PAUSE_EN adds pause_btn / paused.            Revision: 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface game_sequencer_if;
    logic       vsync_in;
    logic       start_click;
    logic       point_scored;
    logic       point_winner;
    logic [3:0] score_pl1;
    logic [3:0] score_pl2;
    logic       enable_menu;
    logic       physics_run;
    logic       physics_reset;
    logic       serve_side;
    logic       endgame;
    logic       winner;
    logic [2:0] state;
`ifdef GAME_PAUSE_EN
    logic       pause_btn;
    logic       paused;

    modport master (
        input  vsync_in, start_click, point_scored, point_winner, pause_btn,
        output score_pl1, score_pl2, enable_menu, physics_run, physics_reset,
               serve_side, endgame, winner, state, paused
    );
    modport slave (
        output vsync_in, start_click, point_scored, point_winner, pause_btn,
        input  score_pl1, score_pl2, enable_menu, physics_run, physics_reset,
               serve_side, endgame, winner, state, paused
    );
`else
    modport master (
        input  vsync_in, start_click, point_scored, point_winner,
        output score_pl1, score_pl2, enable_menu, physics_run, physics_reset,
               serve_side, endgame, winner, state
    );
    modport slave (
        output vsync_in, start_click, point_scored, point_winner,
        input  score_pl1, score_pl2, enable_menu, physics_run, physics_reset,
               serve_side, endgame, winner, state
    );
`endif
endinterface

`default_nettype wire

// File: rtl/game_sequencer.sv
// +----------------------------------------------------------------------------+
// | game_sequencer : frame-timed menu/serve/rally/point/gameover controller     |
// | Optional feature macro: GAME_PAUSE_EN (pause toggle).      Revision: 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module game_sequencer #(
    parameter int WIN_SCORE    = 15,
    parameter int SERVE_FRAMES = 30,
    parameter int PAUSE_FRAMES = 120
) (
    input  wire logic         pclk,
    input  wire logic         rst,
    game_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        ST_MENU     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_RALLY    = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam logic [3:0] C_WIN        = 4'(WIN_SCORE);
    localparam logic [7:0] C_SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] C_PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

    state_t     r_state;
    logic       r_vs_prev;
    logic       r_click_prev;
    logic [7:0] r_frame_cnt;
    logic [3:0] r_score_pl1;
    logic [3:0] r_score_pl2;
    logic       r_enable_menu;
    logic       r_physics_run;
    logic       r_physics_reset;
    logic       r_serve_side;
    logic       r_endgame;
    logic       r_winner;

    logic       w_tick;
    logic       w_click;
    logic       w_frozen;
    logic       w_paused_nxt;
    logic [3:0] w_scorer_cur;
    logic [3:0] w_score_inc;
    logic       w_win;

    assign w_tick       = bus.vsync_in & ~r_vs_prev;
    assign w_click      = bus.start_click & ~r_click_prev;
    assign w_scorer_cur = bus.point_winner ? r_score_pl2 : r_score_pl1;
    assign w_score_inc  = (w_scorer_cur == 4'd15) ? 4'd15 : w_scorer_cur + 4'd1;
    assign w_win        = (w_score_inc == C_WIN);

`ifdef GAME_PAUSE_EN
    logic r_pause_prev;
    logic r_paused;
    logic w_in_play;

    assign w_in_play    = (r_state == ST_SERVE) || (r_state == ST_RALLY) || (r_state == ST_POINT);
    assign w_paused_nxt = r_paused ^ (bus.pause_btn & ~r_pause_prev & w_in_play);
    assign w_frozen     = r_paused;
    assign bus.paused   = r_paused;
`else
    assign w_paused_nxt = 1'b0;
    assign w_frozen     = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_state         <= ST_MENU;
            r_vs_prev       <= bus.vsync_in;
            r_click_prev    <= bus.start_click;
            r_frame_cnt     <= 8'd0;
            r_score_pl1     <= 4'd0;
            r_score_pl2     <= 4'd0;
            r_enable_menu   <= 1'b1;
            r_physics_run   <= 1'b0;
            r_physics_reset <= 1'b0;
            r_serve_side    <= 1'b0;
            r_endgame       <= 1'b0;
            r_winner        <= 1'b0;
`ifdef GAME_PAUSE_EN
            r_pause_prev    <= bus.pause_btn;
            r_paused        <= 1'b0;
`endif
        end else begin
            r_vs_prev       <= bus.vsync_in;
            r_click_prev    <= bus.start_click;
            r_physics_reset <= 1'b0;
`ifdef GAME_PAUSE_EN
            r_pause_prev    <= bus.pause_btn;
            r_paused        <= w_paused_nxt;
`endif
            case (r_state)
                ST_MENU: begin
                    r_enable_menu <= 1'b1;
                    r_physics_run <= 1'b0;
                    if (w_click) begin
                        r_state         <= ST_SERVE;
                        r_score_pl1     <= 4'd0;
                        r_score_pl2     <= 4'd0;
                        r_serve_side    <= 1'b0;
                        r_physics_reset <= 1'b1;
                        r_enable_menu   <= 1'b0;
                        r_frame_cnt     <= 8'd0;
                    end
                end
                ST_SERVE: begin
                    r_physics_run <= 1'b0;
                    if (!w_frozen && w_tick) begin
                        if (r_frame_cnt == C_SERVE_LAST) begin
                            r_state       <= ST_RALLY;
                            r_frame_cnt   <= 8'd0;
                            r_physics_run <= ~w_paused_nxt;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                end
                ST_RALLY: begin
                    r_physics_run <= ~w_paused_nxt;
                    // A point takes priority over any frame tick in the same cycle.
                    if (!w_frozen && bus.point_scored) begin
                        r_serve_side  <= bus.point_winner;
                        r_frame_cnt   <= 8'd0;
                        r_physics_run <= 1'b0;
                        if (bus.point_winner)
                            r_score_pl2 <= w_score_inc;
                        else
                            r_score_pl1 <= w_score_inc;
                        if (w_win) begin
                            r_state       <= ST_GAMEOVER;
                            r_winner      <= bus.point_winner;
                            r_endgame     <= 1'b1;
                            r_enable_menu <= 1'b1;
`ifdef GAME_PAUSE_EN
                            r_paused      <= 1'b0;
`endif
                        end else begin
                            r_state <= ST_POINT;
                        end
                    end
                end
                ST_POINT: begin
                    r_physics_run <= 1'b0;
                    if (!w_frozen && w_tick) begin
                        if (r_frame_cnt == C_PAUSE_LAST) begin
                            r_state         <= ST_SERVE;
                            r_frame_cnt     <= 8'd0;
                            r_physics_reset <= 1'b1;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                end
                ST_GAMEOVER: begin
                    r_endgame     <= 1'b1;
                    r_enable_menu <= 1'b1;
                    r_physics_run <= 1'b0;
                    if (w_click) begin
                        r_state     <= ST_MENU;
                        r_endgame   <= 1'b0;
                        r_frame_cnt <= 8'd0;
                    end
                end
                default: begin
                    r_state       <= ST_MENU;
                    r_enable_menu <= 1'b1;
                    r_physics_run <= 1'b0;
                    r_endgame     <= 1'b0;
                    r_frame_cnt   <= 8'd0;
`ifdef GAME_PAUSE_EN
                    r_paused      <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign bus.score_pl1     = r_score_pl1;
    assign bus.score_pl2     = r_score_pl2;
    assign bus.enable_menu   = r_enable_menu;
    assign bus.physics_run   = r_physics_run;
    assign bus.physics_reset = r_physics_reset;
    assign bus.serve_side    = r_serve_side;
    assign bus.endgame       = r_endgame;
    assign bus.winner        = r_winner;
    assign bus.state         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_game_sequencer : directed self-checking bench for game_sequencer         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_game_sequencer;

    logic pclk = 1'b0;
    logic rst  = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    game_sequencer_if gif();

    game_sequencer #(
        .WIN_SCORE    (3),
        .SERVE_FRAMES (2),
        .PAUSE_FRAMES (3)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (gif.master)
    );

    always #5 pclk = ~pclk;

    // Packed view: state, score_pl1, score_pl2, enable_menu, physics_run,
    // physics_reset, serve_side, endgame, winner
    function automatic logic [16:0] outs();
        return {gif.state, gif.score_pl1, gif.score_pl2, gif.enable_menu, gif.physics_run,
                gif.physics_reset, gif.serve_side, gif.endgame, gif.winner};
    endfunction

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic tick();
        gif.vsync_in = 1'b1;
        cyc();
        gif.vsync_in = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        gif.vsync_in = 1'b0; gif.start_click = 1'b0;
        gif.point_scored = 1'b0; gif.point_winner = 1'b0;
        cyc(); cyc();
        vectors++;
        if (outs() !== {3'd0, 4'd0, 4'd0, 6'b100000}) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", outs(), {3'd0, 4'd0, 4'd0, 6'b100000});
        end
        rst = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (outs() !== {3'd0, 4'd0, 4'd0, 6'b100000}) begin
            miscompares++;
            $display("FAIL menu_idle_vsync: got %h expected %h", outs(), {3'd0, 4'd0, 4'd0, 6'b100000});
        end
    endtask

    task automatic test_start();
        gif.start_click = 1'b1;
        cyc();
        vectors++;
        if (outs() !== {3'd1, 4'd0, 4'd0, 6'b001000}) begin
            miscompares++;
            $display("FAIL start_enter_serve: got %h expected %h", outs(), {3'd1, 4'd0, 4'd0, 6'b001000});
        end
        gif.start_click = 1'b0;
        cyc();
        vectors++;
        if (gif.physics_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL start_reset_pulse_width: got %b expected 0", gif.physics_reset);
        end
        tick();
        vectors++;
        if (gif.state !== 3'd1) begin
            miscompares++;
            $display("FAIL serve_after_one_tick: got %0d expected 1", gif.state);
        end
        tick();
        vectors++;
        if ({gif.state, gif.physics_run} !== {3'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL serve_to_rally: got state %0d run %b expected state 2 run 1", gif.state, gif.physics_run);
        end
    endtask

    task automatic test_point();
        gif.point_scored = 1'b1; gif.point_winner = 1'b1;
        cyc();
        gif.point_scored = 1'b0;
        vectors++;
        if (outs() !== {3'd3, 4'd0, 4'd1, 6'b000100}) begin
            miscompares++;
            $display("FAIL point_pl2: got %h expected %h", outs(), {3'd3, 4'd0, 4'd1, 6'b000100});
        end
        tick(); tick();
        vectors++;
        if (gif.state !== 3'd3) begin
            miscompares++;
            $display("FAIL point_hold_two_ticks: got %0d expected 3", gif.state);
        end
        gif.vsync_in = 1'b1;
        cyc();
        vectors++;
        if ({gif.state, gif.physics_reset} !== {3'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL point_to_serve: got state %0d rst %b expected state 1 rst 1", gif.state, gif.physics_reset);
        end
        gif.vsync_in = 1'b0;
        cyc();
        vectors++;
        if ({gif.state, gif.physics_reset} !== {3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL point_reset_pulse_width: got state %0d rst %b expected state 1 rst 0", gif.state, gif.physics_reset);
        end
    endtask

    task automatic test_gameover();
        for (int i = 0; i < 3; i++) begin
            tick(); tick();
            gif.point_scored = 1'b1; gif.point_winner = 1'b0;
            cyc();
            gif.point_scored = 1'b0;
            if (i < 2) begin
                vectors++;
                if ({gif.state, gif.score_pl1} !== {3'd3, 4'(i + 1)}) begin
                    miscompares++;
                    $display("FAIL pl1_point_%0d: got state %0d score %0d expected state 3 score %0d",
                             i, gif.state, gif.score_pl1, i + 1);
                end
                tick(); tick(); tick();
            end
        end
        vectors++;
        if (outs() !== {3'd4, 4'd3, 4'd1, 6'b100010}) begin
            miscompares++;
            $display("FAIL gameover_entry: got %h expected %h", outs(), {3'd4, 4'd3, 4'd1, 6'b100010});
        end
        tick();
        vectors++;
        if (outs() !== {3'd4, 4'd3, 4'd1, 6'b100010}) begin
            miscompares++;
            $display("FAIL gameover_hold: got %h expected %h", outs(), {3'd4, 4'd3, 4'd1, 6'b100010});
        end
        gif.start_click = 1'b1;
        cyc();
        gif.start_click = 1'b0;
        vectors++;
        if (outs() !== {3'd0, 4'd3, 4'd1, 6'b100000}) begin
            miscompares++;
            $display("FAIL gameover_to_menu: got %h expected %h", outs(), {3'd0, 4'd3, 4'd1, 6'b100000});
        end
        cyc();
        gif.start_click = 1'b1;
        cyc();
        gif.start_click = 1'b0;
        vectors++;
        if (outs() !== {3'd1, 4'd0, 4'd0, 6'b001000}) begin
            miscompares++;
            $display("FAIL restart_clears_scores: got %h expected %h", outs(), {3'd1, 4'd0, 4'd0, 6'b001000});
        end
        cyc();
    endtask

    task automatic test_collision();
        gif.point_scored = 1'b1; gif.point_winner = 1'b1;
        cyc();
        gif.point_scored = 1'b0;
        vectors++;
        if ({gif.state, gif.score_pl1, gif.score_pl2} !== {3'd1, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL point_in_serve_ignored: got state %0d scores %0d/%0d expected 1 0/0",
                     gif.state, gif.score_pl1, gif.score_pl2);
        end
        tick(); tick();
        gif.point_scored = 1'b1; gif.point_winner = 1'b0; gif.vsync_in = 1'b1;
        cyc();
        gif.point_scored = 1'b0; gif.vsync_in = 1'b0;
        vectors++;
        if ({gif.state, gif.score_pl1, gif.score_pl2} !== {3'd3, 4'd1, 4'd0}) begin
            miscompares++;
            $display("FAIL point_and_tick: got state %0d scores %0d/%0d expected 3 1/0",
                     gif.state, gif.score_pl1, gif.score_pl2);
        end
        cyc();
        vectors++;
        if (gif.state !== 3'd3) begin
            miscompares++;
            $display("FAIL point_and_tick_settle: got %0d expected 3", gif.state);
        end
    endtask

    task automatic test_reset_mid_pause();
        tick(); tick();
        vectors++;
        if (gif.state !== 3'd3) begin
            miscompares++;
            $display("FAIL pause_cnt2_state: got %0d expected 3", gif.state);
        end
        rst = 1'b0; gif.start_click = 1'b1;
        cyc();
        vectors++;
        if (outs() !== {3'd0, 4'd0, 4'd0, 6'b100000}) begin
            miscompares++;
            $display("FAIL reset_mid_pause: got %h expected %h", outs(), {3'd0, 4'd0, 4'd0, 6'b100000});
        end
        rst = 1'b1;
        cyc(); cyc();
        vectors++;
        if (gif.state !== 3'd0) begin
            miscompares++;
            $display("FAIL held_click_no_start: got %0d expected 0", gif.state);
        end
        gif.start_click = 1'b0;
        cyc();
        gif.start_click = 1'b1;
        cyc();
        gif.start_click = 1'b0;
        vectors++;
        if ({gif.state, gif.physics_reset} !== {3'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL repress_starts: got state %0d rst %b expected state 1 rst 1", gif.state, gif.physics_reset);
        end
    endtask

`ifdef GAME_PAUSE_EN
    initial gif.pause_btn = 1'b0;
`endif

    initial begin
        test_reset();
        test_start();
        test_point();
        test_gameover();
        test_collision();
        test_reset_mid_pause();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
